// File: rtl/rw_stage.sv
// Register-writeback stage: MA/RW latch, writeback select, 16x32 regfile, retire counter. RF_BYPASS_EN enables write-through reads.
// Latency MA->regfile 2 edges; never stalls, stall/flush from MA insert a bubble.
module rw_stage #(
   parameter int          NREG     = 16,
   parameter int          RA_IDX   = 15,
   parameter int          SP_IDX   = 14,
   parameter logic [31:0] SP_RESET = 32'h0000_FFFC
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ma_valid,
   input  logic [31:0] ma_pc,
   input  logic [31:0] ma_alu,
   input  logic [31:0] ma_ld,
   input  logic [3:0]  ma_rd,
   input  logic        ma_is_ld,
   input  logic        ma_is_call,
   input  logic        ma_is_wb,
   input  logic        stall,
   input  logic        flush,
   input  logic [3:0]  rs1_addr,
   input  logic [3:0]  rs2_addr,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   output logic        wb_en,
   output logic [3:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic [31:0] retired
);

   localparam logic [3:0] RA_ADDR = 4'(RA_IDX);

   logic        validQ;
   logic [31:0] pcQ;
   logic [31:0] aluQ;
   logic [31:0] ldQ;
   logic [3:0]  rdQ;
   logic        isLdQ;
   logic        isCallQ;
   logic        isWbQ;
   logic [31:0] regFile [0:NREG-1];

   // Payload fields hold their last value across bubbles; only validQ is cleared.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         validQ  <= 1'b0;
         pcQ     <= '0;
         aluQ    <= '0;
         ldQ     <= '0;
         rdQ     <= '0;
         isLdQ   <= 1'b0;
         isCallQ <= 1'b0;
         isWbQ   <= 1'b0;
      end else if (flush || stall || !ma_valid) begin
         validQ <= 1'b0;
      end else begin
         validQ  <= 1'b1;
         pcQ     <= ma_pc;
         aluQ    <= ma_alu;
         ldQ     <= ma_ld;
         rdQ     <= ma_rd;
         isLdQ   <= ma_is_ld;
         isCallQ <= ma_is_call;
         isWbQ   <= ma_is_wb;
      end
   end

   // Call takes priority over load when both flags are set.
   always_comb begin
      wb_en   = validQ & (isWbQ | isCallQ);
      wb_addr = rdQ;
      wb_data = aluQ;
      if (isCallQ) begin
         wb_addr = RA_ADDR;
         wb_data = pcQ + 32'd4;
      end else if (isLdQ) begin
         wb_data = ldQ;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            regFile[i] <= (i == SP_IDX) ? SP_RESET : 32'd0;
         end
      end else if (wb_en) begin
         regFile[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retired <= '0;
      end else if (validQ) begin
         retired <= retired + 32'd1;
      end
   end

`ifdef RF_BYPASS_EN
   always_comb begin
      rs1_data = (wb_en && (rs1_addr == wb_addr)) ? wb_data : regFile[rs1_addr];
      rs2_data = (wb_en && (rs2_addr == wb_addr)) ? wb_data : regFile[rs2_addr];
   end
`else
   always_comb begin
      rs1_data = regFile[rs1_addr];
      rs2_data = regFile[rs2_addr];
   end
`endif

endmodule

// File: tb/tb_rw_stage.sv
// Randomized and directed bench for rw_stage against a transaction-level model of the RW stage.
module tb_rw_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ma_valid, ma_is_ld, ma_is_call, ma_is_wb, stall, flush;
   logic [31:0] ma_pc, ma_alu, ma_ld;
   logic [3:0]  ma_rd, rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data, wb_data, retired;
   logic        wb_en;
   logic [3:0]  wb_addr;

   rw_stage dut (
      .clk(clk), .reset_n(reset_n), .ma_valid(ma_valid), .ma_pc(ma_pc), .ma_alu(ma_alu),
      .ma_ld(ma_ld), .ma_rd(ma_rd), .ma_is_ld(ma_is_ld), .ma_is_call(ma_is_call),
      .ma_is_wb(ma_is_wb), .stall(stall), .flush(flush), .rs1_addr(rs1_addr),
      .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_en(wb_en),
      .wb_addr(wb_addr), .wb_data(wb_data), .retired(retired)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nPass   = 0;
   bit checkOn = 1'b0;

   // Model: the instruction currently in RW plus architectural state.
   bit          mValid;
   bit          mWen;
   logic [3:0]  mAddr;
   logic [31:0] mData;
   logic [31:0] mRegs [16];
   logic [31:0] mRetired;

`ifdef RF_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic modelReset();
      mValid   = 1'b0;
      mWen     = 1'b0;
      mAddr    = '0;
      mData    = '0;
      mRetired = '0;
      foreach (mRegs[i]) mRegs[i] = (i == 14) ? 32'h0000_FFFC : 32'd0;
   endtask

   function automatic logic [31:0] expRs(input logic [3:0] a);
      if (BYPASS && mValid && mWen && (a == mAddr)) return mData;
      return mRegs[a];
   endfunction

   task automatic idleInputs();
      ma_valid = 0; ma_is_ld = 0; ma_is_call = 0; ma_is_wb = 0; stall = 0; flush = 0;
      ma_pc = 0; ma_alu = 0; ma_ld = 0; ma_rd = 0;
   endtask

   task automatic op(input bit wb, input bit ld, input bit call, input logic [3:0] rd,
                     input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] ldv);
      ma_valid = 1; ma_is_wb = wb; ma_is_ld = ld; ma_is_call = call; ma_rd = rd;
      ma_pc = pc; ma_alu = alu; ma_ld = ldv; stall = 0; flush = 0;
   endtask

   // One clock edge: retire what sits in RW, then capture from MA; returns 1ns after the edge.
   task automatic cycle();
      @(posedge clk);
      if (reset_n) begin
         if (mValid) begin
            if (mWen) mRegs[mAddr] = mData;
            mRetired = mRetired + 32'd1;
         end
         if (ma_valid && !stall && !flush) begin
            mValid = 1'b1;
            mWen   = ma_is_wb || ma_is_call;
            mAddr  = ma_is_call ? 4'd15 : ma_rd;
            mData  = ma_is_call ? ma_pc + 32'd4 : (ma_is_ld ? ma_ld : ma_alu);
         end else begin
            mValid = 1'b0;
         end
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (checkOn) begin
         chk("wb_en", {31'd0, wb_en}, {31'd0, mValid && mWen});
         if (mValid && mWen) begin
            chk("wb_addr", {28'd0, wb_addr}, {28'd0, mAddr});
            chk("wb_data", wb_data, mData);
         end
         chk("retired", retired, mRetired);
         chk("rs1_data", rs1_data, expRs(rs1_addr));
         chk("rs2_data", rs2_data, expRs(rs2_addr));
      end
   end

   logic [31:0] snap;

   initial begin
      idleInputs();
      rs1_addr = 4'd14; rs2_addr = 4'd3;
      reset_n = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #2;
      chk("reset_rs1_sp", rs1_data, 32'h0000_FFFC);
      chk("reset_rs2_r3", rs2_data, 32'd0);
      chk("reset_wb_en", {31'd0, wb_en}, 32'd0);
      chk("reset_wb_addr", {28'd0, wb_addr}, 32'd0);
      chk("reset_wb_data", wb_data, 32'd0);
      chk("reset_retired", retired, 32'd0);
      checkOn = 1'b1;
      reset_n = 1'b1;
      cycle();

      // ALU writeback to r5
      op(1, 0, 0, 4'd5, 32'h0, 32'h1234, 32'h0);
      rs1_addr = 4'd5;
      cycle();
      idleInputs();
      chk("alu_wb_en", {31'd0, wb_en}, 32'd1);
      chk("alu_wb_data", wb_data, 32'h1234);
      chk("alu_wb_addr", {28'd0, wb_addr}, 32'd5);
      cycle();
      chk("alu_reg5", rs1_data, 32'h1234);
      chk("alu_retired", retired, 32'd1);

      // Load to r2, then call (with is_ld also set) from pc 0x40 naming r7
      op(1, 1, 0, 4'd2, 32'h0, 32'h5555, 32'hDEADBEEF);
      cycle();
      op(1, 1, 1, 4'd7, 32'h40, 32'h6666, 32'h999);
      cycle();
      idleInputs();
      rs1_addr = 4'd2;
      cycle();
      chk("load_reg2", rs1_data, 32'hDEADBEEF);
      rs1_addr = 4'd15; rs2_addr = 4'd7;
      #1;
      chk("call_reg15", rs1_data, 32'h44);
      chk("call_reg7", rs2_data, 32'd0);

      // Stalled op, flushed op, stall+flush: all bubbles
      snap = retired;
      op(1, 0, 0, 4'd6, 32'h0, 32'hAAAA, 32'h0); stall = 1;
      cycle();
      chk("stall_wb_en", {31'd0, wb_en}, 32'd0);
      stall = 0; flush = 1;
      cycle();
      chk("flush_wb_en", {31'd0, wb_en}, 32'd0);
      stall = 1;
      cycle();
      chk("stflush_wb_en", {31'd0, wb_en}, 32'd0);
      idleInputs();
      cycle();
      chk("bubble_retired", retired, snap);
      op(0, 0, 0, 4'd6, 32'h0, 32'hBBBB, 32'h0);
      cycle();
      idleInputs();
      chk("store_wb_en", {31'd0, wb_en}, 32'd0);
      cycle();
      chk("store_retired", retired, snap + 32'd1);
      rs1_addr = 4'd6; #1;
      chk("store_reg6", rs1_data, 32'd0);

      // Write-through visibility on r3
      rs1_addr = 4'd3;
      op(1, 0, 0, 4'd3, 32'h0, 32'hA5, 32'h0);
      cycle();
      idleInputs();
      chk("bypass_rs1", rs1_data, BYPASS ? 32'hA5 : 32'd0);
      cycle();
      chk("after_write_rs1", rs1_data, 32'hA5);

      // Retire counter wrap
      force dut.retired = 32'hFFFF_FFFF;
      #1;
      release dut.retired;
      mRetired = 32'hFFFF_FFFF;
      op(0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0);
      cycle();
      idleInputs();
      cycle();
      chk("retired_wrap", retired, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         ma_valid   = ($urandom_range(0, 3) != 0);
         ma_is_wb   = ($urandom_range(0, 3) != 0);
         ma_is_ld   = $urandom_range(0, 1) == 1;
         ma_is_call = ($urandom_range(0, 7) == 0);
         stall      = ($urandom_range(0, 5) == 0);
         flush      = ($urandom_range(0, 7) == 0);
         ma_rd      = 4'($urandom_range(0, 15));
         ma_pc      = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
         ma_alu     = $urandom;
         ma_ld      = $urandom;
         rs1_addr   = ($urandom_range(0, 1) == 1) ? mAddr : 4'($urandom_range(0, 15));
         rs2_addr   = ($urandom_range(0, 2) == 0) ? rs1_addr : 4'($urandom_range(0, 15));
         cycle();
      end

      // Async reset while a write is pending in RW
      op(1, 0, 0, 4'd9, 32'h0, 32'hC0FFEE, 32'h0);
      rs1_addr = 4'd9; rs2_addr = 4'd14;
      cycle();
      idleInputs();
      chk("pre_reset_wb_en", {31'd0, wb_en}, 32'd1);
      #2;
      reset_n = 1'b0;
      modelReset();
      #1;
      chk("midreset_wb_en", {31'd0, wb_en}, 32'd0);
      chk("midreset_retired", retired, 32'd0);
      cycle();
      reset_n = 1'b1;
      cycle();
      cycle();
      chk("dropped_write_r9", rs1_data, 32'd0);
      chk("midreset_sp", rs2_data, 32'h0000_FFFC);

      checkOn = 1'b0;
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
